// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and flush controller for the in-order pipeline.
// Tracks issued instructions through NSTAGES slots after decode.
module pipe_hazard_ctrl #(
    parameter int RWIDTH    = 5,
    parameter int NSTAGES   = 3,
    parameter int LOADSTAGE = 2,
    parameter int CWIDTH    = 32,
    parameter int FWIDTH    = $clog2(NSTAGES + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid_i,
    input  logic [RWIDTH-1:0] id_rs1_i,
    input  logic [RWIDTH-1:0] id_rs2_i,
    input  logic              id_rs1_used_i,
    input  logic              id_rs2_used_i,
    input  logic [RWIDTH-1:0] id_rd_i,
    input  logic              id_regwren_i,
    input  logic              id_memren_i,
    input  logic              ex_redirect_i,
    output logic              stall_o,
    output logic              flush_o,
    output logic              issue_o,
    output logic [FWIDTH-1:0] fwd_rs1_o,
    output logic [FWIDTH-1:0] fwd_rs2_o,
    output logic [CWIDTH-1:0] stall_cnt_o,
    output logic [CWIDTH-1:0] flush_cnt_o
);

    localparam logic [CWIDTH-1:0] CNT_MAX = '1;

    logic [NSTAGES:1]             valid_q, valid_d;
    logic [NSTAGES:1]             wr_q, wr_d;
    logic [NSTAGES:1]             ld_q, ld_d;
    logic [NSTAGES:1][RWIDTH-1:0] rd_q, rd_d;
    logic [CWIDTH-1:0]            stall_cnt_q, stall_cnt_d;
    logic [CWIDTH-1:0]            flush_cnt_q, flush_cnt_d;

    logic              haz_rs1_s, haz_rs2_s;
    logic [FWIDTH-1:0] sel_rs1_s, sel_rs2_s;

    // Returns {hazard, select}; scanning from slot 1 makes the youngest producer win.
    function automatic logic [FWIDTH:0] operand_check(
        input logic                         used,
        input logic [RWIDTH-1:0]            idx,
        input logic [NSTAGES:1]             v,
        input logic [NSTAGES:1]             w,
        input logic [NSTAGES:1]             l,
        input logic [NSTAGES:1][RWIDTH-1:0] rd
    );
        logic [FWIDTH-1:0] sel;
        logic              haz;
        logic              found;
        sel   = '0;
        haz   = 1'b0;
        found = 1'b0;
        if (used && (idx != '0)) begin
            for (int k = 1; k <= NSTAGES; k++) begin
                if (!found && v[k] && w[k] && (rd[k] == idx)) begin
                    found = 1'b1;
                    if (l[k] && (k < LOADSTAGE)) begin
                        haz = 1'b1;
                    end else begin
                        sel = FWIDTH'(k);
                    end
                end else begin
                    found = found;
                end
            end
        end else begin
            found = 1'b0;
        end
        return {haz, sel};
    endfunction

    // Per-operand hazard detection and control outputs; reset forces everything idle.
    always_comb begin
        {haz_rs1_s, sel_rs1_s} = operand_check(id_rs1_used_i, id_rs1_i, valid_q, wr_q, ld_q, rd_q);
        {haz_rs2_s, sel_rs2_s} = operand_check(id_rs2_used_i, id_rs2_i, valid_q, wr_q, ld_q, rd_q);
        stall_o   = 1'b0;
        flush_o   = 1'b0;
        issue_o   = 1'b0;
        fwd_rs1_o = '0;
        fwd_rs2_o = '0;
        if (reset) begin
            stall_o = 1'b0;
        end else begin
            flush_o   = ex_redirect_i;
            stall_o   = id_valid_i & (haz_rs1_s | haz_rs2_s) & ~ex_redirect_i;
            issue_o   = id_valid_i & ~stall_o & ~ex_redirect_i;
            fwd_rs1_o = sel_rs1_s;
            fwd_rs2_o = sel_rs2_s;
        end
    end

    // Slot shift register: decode enters slot 1, the oldest slot drops off.
    always_comb begin
        valid_d = '0;
        wr_d    = wr_q;
        ld_d    = ld_q;
        rd_d    = rd_q;
        for (int k = NSTAGES; k >= 2; k--) begin
            valid_d[k] = valid_q[k-1];
            wr_d[k]    = wr_q[k-1];
            ld_d[k]    = ld_q[k-1];
            rd_d[k]    = rd_q[k-1];
        end
        valid_d[1] = issue_o;
        wr_d[1]    = id_regwren_i & (id_rd_i != '0);
        ld_d[1]    = id_memren_i;
        rd_d[1]    = id_rd_i;
        if (reset) begin
            valid_d = '0;
        end else begin
            valid_d = valid_d;
        end
    end

    // Saturating event counters.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (reset) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (stall_o && (stall_cnt_q != CNT_MAX)) begin
                stall_cnt_d = stall_cnt_q + CWIDTH'(1);
            end else begin
                stall_cnt_d = stall_cnt_q;
            end
            if (flush_o && (flush_cnt_q != CNT_MAX)) begin
                flush_cnt_d = flush_cnt_q + CWIDTH'(1);
            end else begin
                flush_cnt_d = flush_cnt_q;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        valid_q     <= valid_d;
        wr_q        <= wr_d;
        ld_q        <= ld_d;
        rd_q        <= rd_d;
        stall_cnt_q <= stall_cnt_d;
        flush_cnt_q <= flush_cnt_d;
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: default instance plus a CWIDTH=2 instance for saturation.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid_i;
    logic [4:0] id_rs1_i, id_rs2_i, id_rd_i;
    logic       id_rs1_used_i, id_rs2_used_i, id_regwren_i, id_memren_i, ex_redirect_i;

    logic        stall_o, flush_o, issue_o;
    logic [1:0]  fwd_rs1_o, fwd_rs2_o;
    logic [31:0] stall_cnt_o, flush_cnt_o;

    logic        s_stall_o, s_flush_o, s_issue_o;
    logic [1:0]  s_fwd_rs1_o, s_fwd_rs2_o;
    logic [1:0]  s_stall_cnt_o, s_flush_cnt_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl dut (
        .clk(clk), .reset(reset), .id_valid_i(id_valid_i),
        .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
        .id_rs1_used_i(id_rs1_used_i), .id_rs2_used_i(id_rs2_used_i),
        .id_rd_i(id_rd_i), .id_regwren_i(id_regwren_i), .id_memren_i(id_memren_i),
        .ex_redirect_i(ex_redirect_i),
        .stall_o(stall_o), .flush_o(flush_o), .issue_o(issue_o),
        .fwd_rs1_o(fwd_rs1_o), .fwd_rs2_o(fwd_rs2_o),
        .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
    );

    pipe_hazard_ctrl #(.CWIDTH(2)) dut_sat (
        .clk(clk), .reset(reset), .id_valid_i(id_valid_i),
        .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
        .id_rs1_used_i(id_rs1_used_i), .id_rs2_used_i(id_rs2_used_i),
        .id_rd_i(id_rd_i), .id_regwren_i(id_regwren_i), .id_memren_i(id_memren_i),
        .ex_redirect_i(ex_redirect_i),
        .stall_o(s_stall_o), .flush_o(s_flush_o), .issue_o(s_issue_o),
        .fwd_rs1_o(s_fwd_rs1_o), .fwd_rs2_o(s_fwd_rs2_o),
        .stall_cnt_o(s_stall_cnt_o), .flush_cnt_o(s_flush_cnt_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic drv(input logic v, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                       input logic wr, input logic ld, input logic rdr);
        id_valid_i    = v;
        id_rs1_i      = rs1;
        id_rs1_used_i = u1;
        id_rs2_i      = rs2;
        id_rs2_used_i = u2;
        id_rd_i       = rd;
        id_regwren_i  = wr;
        id_memren_i   = ld;
        ex_redirect_i = rdr;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset: outputs forced idle even with redirect and a valid decode.
        reset = 1'b1;
        drv(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1);
        sample();
        chk("rst_flush", 32'(flush_o), 32'd0);
        chk("rst_issue", 32'(issue_o), 32'd0);
        chk("rst_stall", 32'(stall_o), 32'd0);
        chk("rst_fwd1",  32'(fwd_rs1_o), 32'd0);
        tick();
        drv(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        sample();
        chk("rst_scnt", stall_cnt_o, 32'd0);
        chk("rst_fcnt", flush_cnt_o, 32'd0);
        tick();
        reset = 1'b0;

        // T1: add x5
        drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
        sample();
        chk("t1_issue", 32'(issue_o), 32'd1);
        tick();
        // T2: consumer of x5, writes x8
        drv(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);
        sample();
        chk("alu_fwd1",  32'(fwd_rs1_o), 32'd1);
        chk("alu_stall", 32'(stall_o), 32'd0);
        chk("alu_issue", 32'(issue_o), 32'd1);
        tick();
        // T3: lw x6, reads x5 (slot 2) and x8 (slot 1)
        drv(1'b1, 5'd5, 1'b1, 5'd8, 1'b1, 5'd6, 1'b1, 1'b1, 1'b0);
        sample();
        chk("t3_fwd1", 32'(fwd_rs1_o), 32'd2);
        chk("t3_fwd2", 32'(fwd_rs2_o), 32'd1);
        tick();
        // T4: load-use on x6; x5 now in writeback slot
        drv(1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
        sample();
        chk("lu_stall", 32'(stall_o), 32'd1);
        chk("lu_issue", 32'(issue_o), 32'd0);
        chk("lu_fwd2",  32'(fwd_rs2_o), 32'd0);
        chk("wb_fwd1",  32'(fwd_rs1_o), 32'd3);
        tick();
        // T5: load now in slot 2
        sample();
        chk("lu2_stall", 32'(stall_o), 32'd0);
        chk("lu2_fwd2",  32'(fwd_rs2_o), 32'd2);
        chk("lu2_issue", 32'(issue_o), 32'd1);
        chk("lu2_scnt",  stall_cnt_o, 32'd1);
        chk("lu2_sscnt", 32'(s_stall_cnt_o), 32'd1);
        tick();
        // T6/T7: two writers of x7
        drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
        tick();
        drv(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
        sample();
        chk("t7_fwd1", 32'(fwd_rs1_o), 32'd2);
        tick();
        // T8: youngest x7 wins; this instruction writes x0
        drv(1'b1, 5'd7, 1'b1, 5'd9, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
        sample();
        chk("young_fwd1", 32'(fwd_rs1_o), 32'd1);
        chk("young_fwd2", 32'(fwd_rs2_o), 32'd3);
        tick();
        // T9: rs1=x0, rs2=x7 pending but unused
        drv(1'b1, 5'd0, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        sample();
        chk("x0_fwd1",  32'(fwd_rs1_o), 32'd0);
        chk("x0_fwd2",  32'(fwd_rs2_o), 32'd0);
        chk("x0_stall", 32'(stall_o), 32'd0);
        tick();
        // T10: lw x10
        drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 1'b1, 1'b0);
        tick();
        // T11: load-use stall condition plus redirect
        drv(1'b1, 5'd10, 1'b1, 5'd0, 1'b0, 5'd11, 1'b1, 1'b0, 1'b1);
        sample();
        chk("rdr_flush", 32'(flush_o), 32'd1);
        chk("rdr_stall", 32'(stall_o), 32'd0);
        chk("rdr_issue", 32'(issue_o), 32'd0);
        tick();
        // T12: slot 1 is a bubble, so x11 is not forwarded
        drv(1'b1, 5'd10, 1'b1, 5'd11, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        sample();
        chk("rdr2_fwd1", 32'(fwd_rs1_o), 32'd2);
        chk("rdr2_fwd2", 32'(fwd_rs2_o), 32'd0);
        chk("rdr2_fcnt", flush_cnt_o, 32'd1);
        chk("rdr2_scnt", stall_cnt_o, 32'd1);
        chk("rdr2_flush", 32'(flush_o), 32'd0);
        tick();

        // Five more load-use stalls: 6 total; the 2-bit counter stops at 3.
        for (int i = 0; i < 5; i++) begin
            drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd12, 1'b1, 1'b1, 1'b0);
            tick();
            drv(1'b1, 5'd12, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
            sample();
            chk("sat_stall", 32'(stall_o), 32'd1);
            tick();
            sample();
            chk("sat_fwd1", 32'(fwd_rs1_o), 32'd2);
            tick();
        end
        drv(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        sample();
        chk("sat_scnt",  stall_cnt_o, 32'd6);
        chk("sat_sscnt", 32'(s_stall_cnt_o), 32'd3);
        tick();

        // Reset mid-stall with a pending x5 load
        drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
        tick();
        drv(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        sample();
        chk("prr_stall", 32'(stall_o), 32'd1);
        tick();
        reset = 1'b1;
        sample();
        chk("mrst_stall", 32'(stall_o), 32'd0);
        tick();
        reset = 1'b0;
        sample();
        chk("post_fwd1",  32'(fwd_rs1_o), 32'd0);
        chk("post_stall", 32'(stall_o), 32'd0);
        chk("post_issue", 32'(issue_o), 32'd1);
        chk("post_scnt",  stall_cnt_o, 32'd0);
        chk("post_fcnt",  flush_cnt_o, 32'd0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
